mult16_job_ctrl: RTL

- Issue/collect stage that sits directly in front of the 16x16 shift-add multiplier core (mult16x16) and owns its start, operand and result interfaces.
- Buffers operand pairs in a small FIFO and drives the core's start pulse with stable operands.
- Waits a fixed latency, captures the 33-bit product and presents it on a valid/ready result port.
- Turns the core's start/sticky-done protocol into a streaming, backpressured interface for the rest of the datapath.

---
 rtl/mult16_job_ctrl_if.sv | 39 +++
 rtl/mult16_job_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mult16_job_ctrl_if.sv
// mult16_job_ctrl_if
//   Bundles the three handshakes that mult16_job_ctrl owns:
//     - operand intake:   in_valid94 / in_ready94 / in_a94 / in_b94
//     - multiplier core:  St94 / Mplier94 / Mcand94 / Prod94 / done94
//     - result delivery:  out_valid94 / out_ready94 / out_prod94 / out_err94
//   plus the busy94 status flag.
//   slave  : the job controller's view (drives ready, core controls, results).
//   master : the surrounding datapath / bench view.
interface mult16_job_ctrl_if;
    logic        in_valid94;
    logic        in_ready94;
    logic [15:0] in_a94;
    logic [15:0] in_b94;

    logic        St94;
    logic [15:0] Mplier94;
    logic [15:0] Mcand94;
    logic [32:0] Prod94;
    logic        done94;

    logic        out_valid94;
    logic        out_ready94;
    logic [32:0] out_prod94;
    logic        out_err94;

    logic        busy94;

    modport slave (
        input  in_valid94, in_a94, in_b94, Prod94, done94, out_ready94,
        output in_ready94, St94, Mplier94, Mcand94,
               out_valid94, out_prod94, out_err94, busy94
    );

    modport master (
        output in_valid94, in_a94, in_b94, Prod94, done94, out_ready94,
        input  in_ready94, St94, Mplier94, Mcand94,
               out_valid94, out_prod94, out_err94, busy94
    );
endinterface

// File: rtl/mult16_job_ctrl.sv
// mult16_job_ctrl
//   Issue/collect stage in front of the 16x16 shift-add multiplier core.
//   Operand pairs are queued in a DEPTH-entry FIFO. When idle and no result
//   is pending, the head pair is popped onto Mplier94/Mcand94 and St94 is
//   pulsed for START_W cycles. LAT cycles after St94 falls the core product
//   is captured together with an error flag (done94 was still low) and
//   offered on a valid/ready result port.
//
// Ports
//   clk94  : clock, rising edge
//   rst94  : asynchronous active-high reset
//   bus    : mult16_job_ctrl_if.slave
//            in_valid94/in_ready94/in_a94/in_b94  operand intake
//            St94/Mplier94/Mcand94                 core start + operands
//            Prod94/done94                         core product + sticky done
//            out_valid94/out_ready94               result handshake
//            out_prod94/out_err94                  captured product + error
//            busy94                                FSM not idle
module mult16_job_ctrl #(
    parameter int DEPTH   = 4,
    parameter int START_W = 2,
    parameter int LAT     = 40
) (
    input  logic             clk94,
    input  logic             rst94,
    mult16_job_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (START_W > 1) ? $clog2(START_W) : 1;

    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] PULSE_LAST = PW'(START_W - 1);
    localparam logic [7:0]    LAT_LAST   = 8'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operand FIFO
    logic [15:0]   mem_a [DEPTH];
    logic [15:0]   mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Job FSM
    state_t        state;
    logic [PW-1:0] pulse_cnt;
    logic [7:0]    lat_cnt;

    // Ready comes straight from the registered count, so a full FIFO only
    // reopens the cycle after a pop has actually been taken.
    assign bus.in_ready94 = (count != FULL_CNT);
    assign push           = bus.in_valid94 && bus.in_ready94;

    // The only pop point is the IDLE->START decision; a pending result
    // blocks it so no new job starts while out_prod94 is still owned.
    assign pop = (state == IDLE) && (count != '0) && !bus.out_valid94;

    // FIFO storage carries data only; validity lives in count/pointers.
    always_ff @(posedge clk94) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a94;
            mem_b[wr_ptr] <= bus.in_b94;
        end
    end

    always_ff @(posedge clk94 or posedge rst94) begin
        if (rst94) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Job sequencing. All core-facing and result outputs are registered here.
    // Mplier94/Mcand94 only load on a pop, so they stay stable from the start
    // pulse through the result handshake.
    always_ff @(posedge clk94 or posedge rst94) begin
        if (rst94) begin
            state           <= IDLE;
            pulse_cnt       <= '0;
            lat_cnt         <= '0;
            bus.St94        <= 1'b0;
            bus.Mplier94    <= '0;
            bus.Mcand94     <= '0;
            bus.out_valid94 <= 1'b0;
            bus.out_prod94  <= '0;
            bus.out_err94   <= 1'b0;
            bus.busy94      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.Mplier94 <= mem_a[rd_ptr];
                        bus.Mcand94  <= mem_b[rd_ptr];
                        bus.St94     <= 1'b1;
                        pulse_cnt    <= '0;
                        bus.busy94   <= 1'b1;
                        state        <= START;
                    end
                end

                START: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        bus.St94 <= 1'b0;
                        lat_cnt  <= '0;
                        state    <= WAIT;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end

                // lat_cnt is 0 in the first cycle after St94 falls, so the
                // capture edge lands exactly LAT cycles after the fall.
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        bus.out_prod94  <= bus.Prod94;
                        bus.out_err94   <= !bus.done94;
                        bus.out_valid94 <= 1'b1;
                        state           <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                // out_prod94/out_err94 intentionally keep their value after
                // the handshake.
                DONE: begin
                    if (bus.out_ready94) begin
                        bus.out_valid94 <= 1'b0;
                        bus.busy94      <= 1'b0;
                        state           <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
